vga_token_renderer: RTL and testbench
=====================================

Name: vga_token_renderer

Overview:
- Display stage directly downstream of the token buffer.
- Consumes the 384-bit buffer (96 four-bit tokens) and generates 640x480@60 VGA timing.
- Renders the tokens as two text rows of 48 glyph cells, each 8x8 pixels.
- Samples the buffer once per frame so that a strobe landing mid-frame never tears the image.

Parameters:
- CLK_DIV, 2: system clocks per pixel; the pixel enable pulses every CLK_DIV cycles. Legal values 1..4.
- X0, 128: left pixel column of the text area.
- Y0, 224: top pixel line of the text area.
- FG, 3'b010: RGB colour of lit glyph pixels.
- BG, 3'b000: RGB colour of unlit active-area pixels.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- buffer  in  [0:383]  token buffer; token k (k=0 is the first token entered) occupies bits 380-4k..383-4k
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- rgb  out  [2:0]  pixel colour, forced to 0 outside the active area
- frame_start  out  1  one-clk pulse when the snapshot is taken

Behaviour:
- Reset values: hsync=1, vsync=1, rgb=0, frame_start=0; hcnt=0, vcnt=0; divider=0; snapshot = all ones (all blank); pipeline valid bits cleared.
- Pixel enable (pe):
  - The divider counts 0..CLK_DIV-1; pe=1 when the divider equals CLK_DIV-1.
  - All counters and pipeline registers advance only on pe.
- Horizontal counter hcnt, 0..799:
  - Active 0..639.
  - Sync low at 656..751.
  - Wraps 799 to 0 and increments vcnt.
- Vertical counter vcnt, 0..524:
  - Active 0..479.
  - Sync low at 490..491.
  - Wraps 524 to 0.
- Snapshot:
  - On the pe where hcnt=799 and vcnt=479 (the last pixel before vertical blanking), the snapshot register loads buffer.
  - frame_start pulses for exactly one clk on that cycle.
  - buffer changes at any other time have no effect until the next snapshot.
- Text area:
  - Horizontal extent X0 <= x < X0+384.
  - Vertical extent Y0 <= y < Y0+16.
  - col = (x-X0)>>3, range 0..47.
  - row = (y-Y0)>>3, range 0..1.
  - k = row*48 + col.
  - glyph column = (x-X0)&7, glyph line = (y-Y0)&7; bit 7 is the leftmost pixel.
- Token map:
  - 0-9: digits.
  - A: '+'.
  - B: '-'.
  - C: '*'.
  - D: '/'.
  - E: '='.
  - F: blank (no lit pixels).
- Pipeline, two pe stages:
  - Stage 1 registers the token nibble, glyph line, glyph column, in-text, active, hs and vs.
  - Stage 2 registers the ROM row bit and produces rgb/hsync/vsync.
  - Total latency from counter value to output is 2 pixels. Sync is delayed by the same amount, so the image aligns with sync.
- rgb selection:
  - Active and in-text and lit: FG.
  - Active and not lit: BG.
  - Not active: 0.
- Boundary conditions:
  - Pixels outside the text area are BG even if the token is non-blank.
  - Column x = X0+383 is the last pixel of token 47/95.
  - rst asserted mid-frame returns everything to the reset state on the next clk, regardless of pe, and the pipeline is flushed.
  - After rst, the first snapshot occurs at the first (799,479).

Decomposition:
- Package vga_pkg holds:
  - H_ACTIVE=640, H_FP=16, H_SYNC=96, H_TOTAL=800.
  - V_ACTIVE=480, V_FP=10, V_SYNC=2, V_TOTAL=525.
  - TOK_BLANK=4'hF, NUM_TOKENS=96, TOKENS_PER_ROW=48.
- One sub-module, vga_token_glyph_rom:
  - Combinational 16x8 lines of 8 bits.
  - Inputs: token[3:0], line[2:0]. Output: bits[7:0].
  - Registered by the parent in stage 2.

Test Plan:
- Reset then run CLK_DIV=2: hsync period 1600 clk with a 192-clk low pulse; vsync period 840000 clk with 2 lines low; rgb=0 during blanking.
- Buffer all ones (all blank) -> rgb never equals FG over a full frame; every active pixel is BG.
- Token 0 = 4'h1, rest blank -> lit pixels appear only within x=128..135, y=224..231, matching ROM digit '1' and shifted by exactly 2 pixels of latency relative to the counters.
- Token 48 = 4'hE ('=') -> lit pixels only at x=128..135, y=232..239; token 95 = 4'h8 -> lit pixels only at x=504..511, y=232..239.
- Change buffer while vcnt=300 -> displayed frame unchanged; new content appears only after the next frame_start pulse, which lasts exactly 1 clk.
- Assert rst for 1 clk at hcnt=400, vcnt=100 -> next cycle hsync=1, vsync=1, rgb=0, counters 0, snapshot blank; timing restarts from (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing and token constants for the VGA token display path.
// The timing values describe standard 640x480@60 with a 25 MHz-class pixel rate.
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_TOTAL  = 800;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_TOTAL  = 525;

    localparam logic [3:0] TOK_BLANK      = 4'hF;
    localparam int         NUM_TOKENS     = 96;
    localparam int         TOKENS_PER_ROW = 48;
endpackage

// File: rtl/vga_token_glyph_rom.sv
// 8x8 glyph table for the sixteen token codes: digits, + - * / =, and blank.
// Line 0 is the top line of the cell; bit 7 of each line is its leftmost pixel.
module vga_token_glyph_rom
    import vga_pkg::*;
(
    input  logic [3:0] token,
    input  logic [2:0] line,
    output logic [7:0] bits
);
    logic [63:0] glyph;

    always_comb begin
        glyph = 64'h0;
        case (token)
            4'h0:      glyph = 64'h3C666E7666663C00;
            4'h1:      glyph = 64'h1838181818187E00;
            4'h2:      glyph = 64'h3C66060C30607E00;
            4'h3:      glyph = 64'h3C66061C06663C00;
            4'h4:      glyph = 64'h0C1C3C6C7E0C0C00;
            4'h5:      glyph = 64'h7E607C0606663C00;
            4'h6:      glyph = 64'h3C607C6666663C00;
            4'h7:      glyph = 64'h7E060C1830303000;
            4'h8:      glyph = 64'h3C66663C66663C00;
            4'h9:      glyph = 64'h3C66663E060C3800;
            4'hA:      glyph = 64'h0018187E18180000;
            4'hB:      glyph = 64'h0000007E00000000;
            4'hC:      glyph = 64'h00663CFF3C660000;
            4'hD:      glyph = 64'h02060C1830604000;
            4'hE:      glyph = 64'h00007E007E000000;
            TOK_BLANK: glyph = 64'h0;
        endcase
        // Line 0 sits in the top byte, so the byte offset is 7 - line.
        bits = glyph[{~line, 3'b000} +: 8];
    end
endmodule

// File: rtl/vga_token_renderer.sv
// VGA timing generator that draws a once-per-frame snapshot of the token buffer
// as two rows of 48 glyph cells; timing parameters default to 640x480@60.
module vga_token_renderer
    import vga_pkg::*;
#(
    parameter int         CLK_DIV  = 2,
    parameter int         X0       = 128,
    parameter int         Y0       = 224,
    parameter logic [2:0] FG       = 3'b010,
    parameter logic [2:0] BG       = 3'b000,
    parameter int         H_ACT    = H_ACTIVE,
    parameter int         H_FPORCH = H_FP,
    parameter int         H_SW     = H_SYNC,
    parameter int         H_TOT    = H_TOTAL,
    parameter int         V_ACT    = V_ACTIVE,
    parameter int         V_FPORCH = V_FP,
    parameter int         V_SW     = V_SYNC,
    parameter int         V_TOT    = V_TOTAL
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [0:4*NUM_TOKENS-1]   buffer,
    output logic                      hsync,
    output logic                      vsync,
    output logic [2:0]                rgb,
    output logic                      frame_start
);
    localparam int BUF_W = 4 * NUM_TOKENS;

    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] V_SNAP   = 10'(V_ACT - 1);
    localparam logic [9:0] H_ACT_L  = 10'(H_ACT);
    localparam logic [9:0] V_ACT_L  = 10'(V_ACT);
    localparam logic [9:0] HS_BEG   = 10'(H_ACT + H_FPORCH);
    localparam logic [9:0] HS_END   = 10'(H_ACT + H_FPORCH + H_SW);
    localparam logic [9:0] VS_BEG   = 10'(V_ACT + V_FPORCH);
    localparam logic [9:0] VS_END   = 10'(V_ACT + V_FPORCH + V_SW);
    localparam logic [9:0] X_BEG    = 10'(X0);
    localparam logic [9:0] X_END    = 10'(X0 + 8 * TOKENS_PER_ROW);
    localparam logic [9:0] Y_BEG    = 10'(Y0);
    localparam logic [9:0] Y_END    = 10'(Y0 + 16);

    localparam logic [0:BUF_W-1] SNAP_RESET = {NUM_TOKENS{TOK_BLANK}};

    logic [1:0]       div_q, div_d;
    logic [9:0]       hcnt_q, hcnt_d;
    logic [9:0]       vcnt_q, vcnt_d;
    logic [0:BUF_W-1] snap_q, snap_d;
    logic             frame_start_q, frame_start_d;

    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_tok_q, s1_tok_d;
    logic [2:0]       s1_line_q, s1_line_d;
    logic [2:0]       s1_col_q, s1_col_d;
    logic             s1_text_q, s1_text_d;
    logic             s1_active_q, s1_active_d;
    logic             s1_hs_q, s1_hs_d;
    logic             s1_vs_q, s1_vs_d;

    logic [2:0]       rgb_q, rgb_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;

    logic             pe;
    logic             snap_evt;
    logic [8:0]       dx;
    logic [3:0]       dy;
    logic             in_text;
    logic [6:0]       tok_idx;
    logic [BUF_W-1:0] snap_flat;
    logic [7:0]       glyph_bits;

    vga_token_glyph_rom u_rom (
        .token (s1_tok_q),
        .line  (s1_line_q),
        .bits  (glyph_bits)
    );

    always_comb begin
        pe       = (div_q == DIV_LAST);
        snap_evt = pe && (hcnt_q == H_LAST) && (vcnt_q == V_SNAP);
        div_d    = pe ? 2'd0 : div_q + 2'd1;

        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pe) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = 10'd0;
                vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end

        snap_d        = snap_evt ? buffer : snap_q;
        frame_start_d = snap_evt;

        // Token k is nibble k of the buffer read as one number (token 0 lowest).
        snap_flat = snap_q;
        dx        = 9'(hcnt_q - X_BEG);
        dy        = 4'(vcnt_q - Y_BEG);
        in_text   = (hcnt_q >= X_BEG) && (hcnt_q < X_END) &&
                    (vcnt_q >= Y_BEG) && (vcnt_q < Y_END);
        tok_idx   = 7'd0;
        if (in_text) begin
            tok_idx = dy[3] ? 7'(dx[8:3]) + 7'(TOKENS_PER_ROW) : 7'(dx[8:3]);
        end

        s1_valid_d  = s1_valid_q;
        s1_tok_d    = s1_tok_q;
        s1_line_d   = s1_line_q;
        s1_col_d    = s1_col_q;
        s1_text_d   = s1_text_q;
        s1_active_d = s1_active_q;
        s1_hs_d     = s1_hs_q;
        s1_vs_d     = s1_vs_q;
        rgb_d       = rgb_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;

        if (pe) begin
            s1_valid_d  = 1'b1;
            s1_tok_d    = snap_flat[{tok_idx, 2'b00} +: 4];
            s1_line_d   = dy[2:0];
            s1_col_d    = dx[2:0];
            s1_text_d   = in_text;
            s1_active_d = (hcnt_q < H_ACT_L) && (vcnt_q < V_ACT_L);
            s1_hs_d     = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
            s1_vs_d     = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));

            // Stage 2 only takes real pixels, so the idle outputs hold after reset.
            if (s1_valid_q) begin
                hsync_d = s1_hs_q;
                vsync_d = s1_vs_q;
                if (!s1_active_q) begin
                    rgb_d = 3'b000;
                end else if (s1_text_q && glyph_bits[~s1_col_q]) begin
                    rgb_d = FG;
                end else begin
                    rgb_d = BG;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= 2'd0;
            hcnt_q        <= 10'd0;
            vcnt_q        <= 10'd0;
            snap_q        <= SNAP_RESET;
            frame_start_q <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_tok_q      <= TOK_BLANK;
            s1_line_q     <= 3'd0;
            s1_col_q      <= 3'd0;
            s1_text_q     <= 1'b0;
            s1_active_q   <= 1'b0;
            s1_hs_q       <= 1'b1;
            s1_vs_q       <= 1'b1;
            rgb_q         <= 3'b000;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
        end else begin
            div_q         <= div_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            snap_q        <= snap_d;
            frame_start_q <= frame_start_d;
            s1_valid_q    <= s1_valid_d;
            s1_tok_q      <= s1_tok_d;
            s1_line_q     <= s1_line_d;
            s1_col_q      <= s1_col_d;
            s1_text_q     <= s1_text_d;
            s1_active_q   <= s1_active_d;
            s1_hs_q       <= s1_hs_d;
            s1_vs_q       <= s1_vs_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_token_renderer.sv
// Directed bench for vga_token_renderer on a shortened frame (real 2-clk pixel
// divider, narrow blanking) with a per-clock reference model alongside.
module tb_vga_token_renderer;
    localparam int D     = 2;
    localparam int X0    = 4;
    localparam int Y0    = 2;
    localparam int H_ACT = 392;
    localparam int H_FP  = 4;
    localparam int H_SW  = 8;
    localparam int H_TOT = 408;
    localparam int V_ACT = 20;
    localparam int V_FP  = 1;
    localparam int V_SW  = 2;
    localparam int V_TOT = 24;
    localparam int FRAME = H_TOT * V_TOT;
    localparam logic [2:0] FG = 3'b110;
    localparam logic [2:0] BG = 3'b001;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [0:383] buffer;
    logic         hsync;
    logic         vsync;
    logic [2:0]   rgb;
    logic         frame_start;

    int           total = 0;
    int           bad = 0;
    int           c;
    logic [0:383] msnap;
    bit           mon_en = 1'b0;
    int           t0;
    int           tv;

    vga_token_renderer #(
        .CLK_DIV(D), .X0(X0), .Y0(Y0), .FG(FG), .BG(BG),
        .H_ACT(H_ACT), .H_FPORCH(H_FP), .H_SW(H_SW), .H_TOT(H_TOT),
        .V_ACT(V_ACT), .V_FPORCH(V_FP), .V_SW(V_SW), .V_TOT(V_TOT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .buffer      (buffer),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Clock edge cc (1-based after reset) is pixel tick cc/D; the counters sit at pixel cc/D-1.
    function automatic bit is_snap(input int cc);
        return (cc % D == 0) && (cc > 0) && (((cc / D) - 1) % FRAME == V_ACT * H_TOT - 1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            c     <= 0;
            msnap <= '1;
        end else begin
            c <= c + 1;
            if (is_snap(c + 1)) msnap <= buffer;
        end
    end

    function automatic logic [63:0] font64(input logic [3:0] t);
        case (t)
            4'h0: return 64'h3C666E7666663C00;
            4'h1: return 64'h1838181818187E00;
            4'h2: return 64'h3C66060C30607E00;
            4'h3: return 64'h3C66061C06663C00;
            4'h4: return 64'h0C1C3C6C7E0C0C00;
            4'h5: return 64'h7E607C0606663C00;
            4'h6: return 64'h3C607C6666663C00;
            4'h7: return 64'h7E060C1830303000;
            4'h8: return 64'h3C66663C66663C00;
            4'h9: return 64'h3C66663E060C3800;
            4'hA: return 64'h0018187E18180000;
            4'hB: return 64'h0000007E00000000;
            4'hC: return 64'h00663CFF3C660000;
            4'hD: return 64'h02060C1830604000;
            4'hE: return 64'h00007E007E000000;
            default: return 64'h0;
        endcase
    endfunction

    // Output after clock edge cc shows pixel (cc/D)-2; returns {hsync, vsync, rgb, frame_start}.
    function automatic logic [5:0] exp_out(input int cc, input logic [0:383] sn);
        logic [383:0] num;
        logic [63:0]  g;
        logic [3:0]   tok;
        logic [2:0]   px;
        logic         hs, vs, fs;
        int           n, p, h, v, k, gl, gc;
        num = sn;
        fs  = is_snap(cc);
        n   = cc / D;
        if (n < 2) return {2'b11, 3'b000, fs};
        p  = n - 2;
        h  = p % H_TOT;
        v  = (p / H_TOT) % V_TOT;
        hs = !((h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SW));
        vs = !((v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SW));
        px = 3'b000;
        if (h < H_ACT && v < V_ACT) begin
            px = BG;
            if (h >= X0 && h < X0 + 384 && v >= Y0 && v < Y0 + 16) begin
                k   = ((v - Y0) / 8) * 48 + (h - X0) / 8;
                gl  = (v - Y0) % 8;
                gc  = (h - X0) % 8;
                tok = num[4 * k +: 4];
                g   = font64(tok);
                if (g[63 - 8 * gl - gc]) px = FG;
            end
        end
        return {hs, vs, px, fs};
    endfunction

    function automatic logic [0:383] pat_a();
        logic [383:0] num;
        num            = '1;
        num[3:0]       = 4'h1;
        num[47*4 +: 4] = 4'hC;
        num[48*4 +: 4] = 4'hE;
        num[95*4 +: 4] = 4'h8;
        return num;
    endfunction

    function automatic logic [0:383] pat_b();
        logic [383:0] num;
        num      = '1;
        num[3:0] = 4'h7;
        return num;
    endfunction

    function automatic logic sig(input int w);
        case (w)
            0:       return hsync;
            1:       return vsync;
            default: return frame_start;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_c(input int tgt, input string tag);
        int guard = 0;
        while (c < tgt && guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_sync"}, c, tgt);
    endtask

    task automatic check_px(input int f, input int h, input int v, input logic [2:0] e,
                            input string tag);
        wait_c(D * (f * FRAME + v * H_TOT + h + 2), tag);
        chk(tag, rgb, e);
    endtask

    task automatic wait_sig(input int w, input logic lvl, input int budget, input string tag);
        int n = 0;
        while (sig(w) !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, sig(w), lvl);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (mon_en)
                    chk($sformatf("mon_c%0d", c), {26'd0, hsync, vsync, rgb, frame_start},
                        {26'd0, exp_out(c, msnap)});
            end
        join_none

        buffer = pat_a();
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        chk("rst_hsync", hsync, 1'b1);
        chk("rst_vsync", vsync, 1'b1);
        chk("rst_rgb", rgb, 3'b000);
        chk("rst_fs", frame_start, 1'b0);
        rst = 1'b0;

        // Horizontal timing: sync starts at pixel 396, shown two pixels late.
        wait_sig(0, 1'b0, 2000, "hs_fall");
        chk("hs_fall_time", c, 796);
        t0 = c;
        wait_sig(0, 1'b1, 2000, "hs_rise");
        chk("hs_low_clk", c - t0, 16);
        wait_sig(0, 1'b0, 2000, "hs_fall2");
        chk("hs_period_clk", c - t0, 816);

        // First frame shows the blank reset snapshot.
        check_px(0, 6, 2, BG, "f0_x6y2");
        check_px(0, 7, 2, BG, "f0_x7y2");
        check_px(0, 395, 2, 3'b000, "f0_hblank");

        wait_sig(2, 1'b1, 20000, "fs1");
        chk("fs1_time", c, 16320);
        @(negedge clk);
        chk("fs1_width", frame_start, 1'b0);

        wait_sig(1, 1'b0, 5000, "vs_fall");
        chk("vs_fall_time", c, 17140);
        tv = c;
        wait_sig(1, 1'b1, 5000, "vs_rise");
        chk("vs_low_clk", c - tv, 1632);

        // Frame 1 shows pattern A.
        check_px(1, 6, 2, BG, "f1_tok0_x6");
        check_px(1, 7, 2, FG, "f1_tok0_x7");
        check_px(1, 387, 5, FG, "f1_tok47_last");
        check_px(1, 388, 5, BG, "f1_past_text");
        check_px(1, 395, 5, 3'b000, "f1_hblank");
        check_px(1, 4, 8, BG, "f1_tok0_l6_x4");
        check_px(1, 5, 8, FG, "f1_tok0_l6_x5");
        check_px(1, 5, 10, BG, "f1_tok48_l0");
        check_px(1, 381, 10, BG, "f1_tok95_x381");
        check_px(1, 382, 10, FG, "f1_tok95_x382");

        wait_c(D * (FRAME + 11 * H_TOT + 2), "chg");
        buffer = pat_b();
        check_px(1, 5, 12, FG, "f1_tok48_l2_hold");
        check_px(1, 384, 16, FG, "f1_tok95_l6_hold");

        wait_sig(2, 1'b1, 20000, "fs2");
        chk("fs2_time", c, 16320 + 19584);
        @(negedge clk);
        chk("fs2_width", frame_start, 1'b0);
        wait_sig(1, 1'b0, 5000, "vs_fall2");
        chk("vs_period_clk", c - tv, 19584);

        // Frame 2 shows pattern B.
        check_px(2, 4, 2, BG, "f2_tok0_x4");
        check_px(2, 5, 2, FG, "f2_tok0_x5");
        check_px(2, 382, 10, BG, "f2_tok95_blank");
        check_px(2, 5, 12, BG, "f2_tok48_blank");

        // Reset mid-line while hsync is low.
        wait_c(D * (2 * FRAME + 14 * H_TOT + 400 + 2), "pre_rst");
        chk("pre_rst_hsync", hsync, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_hsync", hsync, 1'b1);
        chk("mid_rst_vsync", vsync, 1'b1);
        chk("mid_rst_rgb", rgb, 3'b000);
        chk("mid_rst_fs", frame_start, 1'b0);
        rst = 1'b0;

        wait_sig(0, 1'b0, 2000, "post_rst_hs_fall");
        chk("post_rst_hs_time", c, 796);
        check_px(0, 5, 2, BG, "post_rst_blank_x5");
        check_px(0, 7, 2, BG, "post_rst_blank_x7");

        mon_en = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
